serial_cfg_tx: RTL and testbench
================================

Name: serial_cfg_tx

Overview:
- Host-side configuration serializer that feeds the backend's serial configuration port (sclk/sdin).
- Accepts a parallel gain word (gainA1 and gainA2 fields) through a valid/ready handshake.
- Waits until the backend reports ready, then shifts the word out MSB-first on a divided sclk.
- Pulses a done strobe after each complete frame. Sits between host/control logic and the backend, replacing ad-hoc serial generation.

Parameters:
- WIDTH, 5, frame length in bits (gainA1[1:0] in the MSBs, then gainA2[2:0]).
- DIV, 2, sclk half-period in i_clk cycles; must be at least 1.
- GAP, 4, idle i_clk cycles after the last falling sclk edge before done.
- TIMEOUT, 64, i_clk cycles to wait for i_ready; 0 disables the timeout.

Ports:
- i_clk  input  1  main clock.
- i_reset  input  1  synchronous reset, active-high.
- i_cfg_word  input  WIDTH  parallel configuration word.
- i_cfg_valid  input  1  word valid.
- o_cfg_ready  output  1  block can accept a word.
- i_ready  input  1  backend ready (backend o_ready), same clock domain.
- o_sclk  output  1  serial clock to backend i_sclk.
- o_sdout  output  1  serial data to backend i_sdin.
- o_busy  output  1  frame in progress (any state other than IDLE).
- o_done  output  1  one-cycle pulse when a frame completes.
- o_timeout  output  1  one-cycle pulse when the wait for i_ready expires.

Behaviour:
- Reset: sync, active-high; takes effect at the next i_clk edge. Values: state=IDLE, o_sclk=0, o_sdout=0, o_busy=0, o_done=0, o_timeout=0, counters=0. o_cfg_ready=1 (combinational: state==IDLE).
- Reset mid-frame: the frame is abandoned, no done/timeout pulse, and all outputs return to reset values on the next edge.
- IDLE: when i_cfg_valid && o_cfg_ready, latch i_cfg_word into the shift register and go to WAIT_RDY. i_cfg_valid in any other state is ignored; there is no queueing.
- WAIT_RDY:
  - o_sclk=0, o_sdout=0.
  - If i_ready=1, go to SHIFT and load o_sdout with the word MSB.
  - Otherwise the wait counter increments. When it reaches TIMEOUT (TIMEOUT>0), pulse o_timeout for one cycle and go to IDLE.
- SHIFT:
  - Divider counter runs 0..DIV-1; at the terminal count o_sclk toggles and the counter clears.
  - Rising toggle (0->1): bit counter +1. Data is stable; the backend samples here.
  - Falling toggle (1->0): if the bit counter < WIDTH, shift the next bit onto o_sdout. Otherwise drive o_sdout=0 and go to GAP.
  - Timing from SHIFT entry at cycle T: first rise at T+DIV; bit k is valid from T+2·DIV·k to T+2·DIV·(k+1); GAP is entered at T+2·DIV·WIDTH.
  - i_ready dropping during SHIFT is ignored; the frame completes.
- GAP: o_sclk=0, o_sdout=0 for GAP cycles. Then pulse o_done for one cycle, go to IDLE, and raise o_cfg_ready in that same cycle.
- Back-to-back frames: a new word may be accepted in the first IDLE cycle after done.
- Widths:
  - bit counter: clog2(WIDTH+1).
  - divider counter: clog2(DIV) (minimum 1).
  - wait counter: clog2(TIMEOUT+1).
  - All counters saturate-free; each clears on its state exit.
- Outputs are registered except o_cfg_ready; o_sclk and o_sdout are glitch-free.

Decomposition:
- Package serial_cfg_pkg holds:
  - state enum {IDLE, WAIT_RDY, SHIFT, GAP};
  - default constants CFG_WIDTH=5, CFG_DIV=2, CFG_GAP=4, CFG_TIMEOUT=64;
  - field offsets GAINA1_MSB=4, GAINA2_MSB=2.
- Sub-module sclk_gen: divider plus toggle, with inputs enable and clear, outputs sclk, rise_stb, fall_stb. The FSM and shift register stay in the top.

Test Plan:
- Reset: i_reset=1 for 3 cycles, then 0 -> o_sclk=0, o_sdout=0, o_cfg_ready=1, o_busy=0, o_done=0, o_timeout=0.
- Nominal frame: word 5'b10110, i_ready=1, DIV=2 -> bits sampled at 5 sclk rises = 1,0,1,1,0; rises at T+2, +6, +10, +14, +18; GAP entered at T+20; o_done pulses at T+24 for exactly 1 cycle.
- Late ready: i_ready=0 for 10 cycles after accept, then 1 -> no sclk edges while waiting; first rise DIV cycles after SHIFT entry; data as in the nominal frame.
- Timeout: i_ready stuck at 0, TIMEOUT=64 -> o_timeout pulses 64 cycles after WAIT_RDY entry; no sclk activity; o_cfg_ready=1 the next cycle; no o_done.
- Busy rejection: word 5'b11111 with valid held during a frame of 5'b00101 -> serialized data is 0,0,1,0,1; 5'b11111 is accepted only in the IDLE cycle after done and sent as the next frame.
- Reset mid-frame: assert i_reset after the 2nd sclk rise -> next edge o_sclk=0, o_sdout=0, o_busy=0; no o_done pulse; a new word is accepted normally.

Source files
------------

// File: rtl/serial_cfg_pkg.sv
// Shared types and defaults for the serial configuration transmitter.
package serial_cfg_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitRdy,
    StShift,
    StGap
  } state_e;

  localparam int unsigned CFG_WIDTH   = 5;
  localparam int unsigned CFG_DIV     = 2;
  localparam int unsigned CFG_GAP     = 4;
  localparam int unsigned CFG_TIMEOUT = 64;

  localparam int unsigned GAINA1_MSB = 4;
  localparam int unsigned GAINA2_MSB = 2;

  // Builds a frame word from the two gain fields.
  function automatic logic [CFG_WIDTH-1:0] cfg_pack(input logic [1:0] gain_a1,
                                                    input logic [2:0] gain_a2);
    logic [CFG_WIDTH-1:0] w;
    w = '0;
    w[GAINA1_MSB -: 2] = gain_a1;
    w[GAINA2_MSB -: 3] = gain_a2;
    return w;
  endfunction

endpackage

// File: rtl/sclk_gen.sv
// Divided serial clock: toggles every DIV enabled cycles, with strobes on the
// cycle a toggle is about to happen.
module sclk_gen #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic enable_i,
  input  logic clear_i,
  output logic sclk_o,
  output logic rise_stb_o,
  output logic fall_stb_o
);

  localparam int unsigned DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DW-1:0] DivLast = DW'(DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          sclk_q, sclk_d;
  logic          tc;

  always_comb begin
    tc     = enable_i && !clear_i && (div_q == DivLast);
    div_d  = div_q;
    sclk_d = sclk_q;
    if (clear_i) begin
      div_d  = '0;
      sclk_d = 1'b0;
    end else if (tc) begin
      div_d  = '0;
      sclk_d = ~sclk_q;
    end else if (enable_i) begin
      div_d = div_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      div_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o     = sclk_q;
  assign rise_stb_o = tc && !sclk_q;
  assign fall_stb_o = tc && sclk_q;

endmodule

// File: rtl/serial_cfg_tx.sv
// Host-side configuration serializer: accepts a parallel word, waits for the
// backend to be ready, then shifts the word out MSB-first on a divided sclk.
module serial_cfg_tx
  import serial_cfg_pkg::*;
#(
  parameter int unsigned WIDTH   = CFG_WIDTH,
  parameter int unsigned DIV     = CFG_DIV,
  parameter int unsigned GAP     = CFG_GAP,
  parameter int unsigned TIMEOUT = CFG_TIMEOUT
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_cfg_word,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic             i_ready,
  output logic             o_sclk,
  output logic             o_sdout,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_timeout
);

  localparam int unsigned BW = $clog2(WIDTH + 1);
  localparam int unsigned WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned GW = (GAP > 1) ? $clog2(GAP) : 1;

  localparam logic [BW-1:0] BitFull  = BW'(WIDTH);
  localparam logic [WW-1:0] WaitLast = WW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GapLast  = GW'(GAP - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic             sdout_q, sdout_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             busy_q, done_q, done_d, timeout_q, timeout_d;
  logic             rise_stb, fall_stb, sclk;

  sclk_gen #(
    .DIV(DIV)
  ) u_sclk_gen (
    .clk_i     (i_clk),
    .reset_i   (i_reset),
    .enable_i  (state_q == StShift),
    .clear_i   (state_q != StShift),
    .sclk_o    (sclk),
    .rise_stb_o(rise_stb),
    .fall_stb_o(fall_stb)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    sdout_d   = sdout_q;
    bit_d     = bit_q;
    wait_d    = wait_q;
    gap_d     = gap_q;
    done_d    = 1'b0;
    timeout_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (i_cfg_valid) begin
          shift_d = i_cfg_word;
          state_d = StWaitRdy;
        end
      end
      StWaitRdy: begin
        if (i_ready) begin
          sdout_d = shift_q[WIDTH-1];
          shift_d = shift_q << 1;
          wait_d  = '0;
          state_d = StShift;
        end else if ((TIMEOUT != 0) && (wait_q == WaitLast)) begin
          timeout_d = 1'b1;
          wait_d    = '0;
          state_d   = StIdle;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      StShift: begin
        if (rise_stb) begin
          bit_d = bit_q + 1'b1;
        end else if (fall_stb) begin
          // bit_q already counts the bit just sampled by the backend
          if (bit_q < BitFull) begin
            sdout_d = shift_q[WIDTH-1];
            shift_d = shift_q << 1;
          end else begin
            sdout_d = 1'b0;
            bit_d   = '0;
            state_d = StGap;
          end
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          gap_d   = '0;
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      sdout_q   <= 1'b0;
      bit_q     <= '0;
      wait_q    <= '0;
      gap_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      sdout_q   <= sdout_d;
      bit_q     <= bit_d;
      wait_q    <= wait_d;
      gap_q     <= gap_d;
      busy_q    <= (state_d != StIdle);
      done_q    <= done_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_cfg_ready = (state_q == StIdle);
  assign o_sclk      = sclk;
  assign o_sdout     = sdout_q;
  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_timeout   = timeout_q;

endmodule

// File: tb/tb_serial_cfg_tx.sv
// Directed bench for serial_cfg_tx: table of frames plus hand-written corner sequences.
module tb_serial_cfg_tx;
  import serial_cfg_pkg::*;

  logic       clk = 1'b0;
  logic       reset, cfg_valid, cfg_ready, rdy, sclk, sdout, busy, done, tmo;
  logic [4:0] cfg_word;

  always #5 clk = ~clk;

  serial_cfg_tx #(
    .WIDTH  (5),
    .DIV    (2),
    .GAP    (4),
    .TIMEOUT(64)
  ) dut (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_cfg_word (cfg_word),
    .i_cfg_valid(cfg_valid),
    .o_cfg_ready(cfg_ready),
    .i_ready    (rdy),
    .o_sclk     (sclk),
    .o_sdout    (sdout),
    .o_busy     (busy),
    .o_done     (done),
    .o_timeout  (tmo)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   rise_cyc[$];
  logic rise_bit[$];
  int   done_cyc[$];
  int   tmo_cyc[$];
  logic sclk_h[200], sdout_h[200], busy_h[200], rdy_h[200];

  typedef struct {
    logic [4:0] word;
    int         ready_dly;
    logic [4:0] exp_bits;
    int         exp_first;
    int         exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Present a word for one edge; returns #1 after the accepting edge (cycle 0).
  task automatic start(input logic [4:0] word);
    @(negedge clk);
    cfg_word  = word;
    cfg_valid = 1'b1;
    rdy       = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Cycle n begins #1 after edge n; inputs set here are sampled at edge n+1.
  task automatic run_cycles(input int ncyc, input int ready_from, input int valid_until,
                            input int reset_at);
    logic prev;
    prev = 1'b0;
    rise_cyc.delete();
    rise_bit.delete();
    done_cyc.delete();
    tmo_cyc.delete();
    for (int n = 0; n < ncyc; n++) begin
      if (n > 0) begin
        @(posedge clk);
        #1;
      end
      rdy       = (n >= ready_from);
      cfg_valid = (n < valid_until);
      reset     = (n == reset_at);
      if (sclk && !prev) begin
        rise_cyc.push_back(n);
        rise_bit.push_back(sdout);
      end
      prev = sclk;
      if (done) done_cyc.push_back(n);
      if (tmo) tmo_cyc.push_back(n);
      sclk_h[n]  = sclk;
      sdout_h[n] = sdout;
      busy_h[n]  = busy;
      rdy_h[n]   = cfg_ready;
    end
    reset     = 1'b0;
    cfg_valid = 1'b0;
  endtask

  task automatic check_frame(input string name, input int base, input logic [4:0] exp_bits,
                             input int exp_first);
    if (rise_cyc.size() < base + 5) begin
      chk({name, " rise count"}, rise_cyc.size() - base, 5);
    end else begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("%s bit%0d", name, k), int'(rise_bit[base+k]), int'(exp_bits[4-k]));
        chk($sformatf("%s rise%0d cycle", name, k), rise_cyc[base+k], exp_first + 4 * k);
      end
    end
  endtask

  initial begin
    vecs[0] = '{5'b10110, 0, 5'b10110, 3, 25};
    vecs[1] = '{5'b10110, 10, 5'b10110, 13, 35};
    vecs[2] = '{5'b00000, 1, 5'b00000, 4, 26};
    vecs[3] = '{5'b11111, 3, 5'b11111, 6, 28};
    vecs[4] = '{5'b01001, 0, 5'b01001, 3, 25};

    reset     = 1'b1;
    cfg_valid = 1'b0;
    cfg_word  = '0;
    rdy       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset sclk", int'(sclk), 0);
    chk("reset sdout", int'(sdout), 0);
    chk("reset cfg_ready", int'(cfg_ready), 1);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    chk("reset timeout", int'(tmo), 0);
    reset = 1'b0;

    for (int i = 0; i < 5; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      start(vecs[i].word);
      run_cycles(vecs[i].exp_done + 4, vecs[i].ready_dly, 0, -1);
      chk({nm, " busy after accept"}, int'(busy_h[0]), 1);
      chk({nm, " cfg_ready after accept"}, int'(rdy_h[0]), 0);
      chk({nm, " rise count"}, rise_cyc.size(), 5);
      check_frame(nm, 0, vecs[i].exp_bits, vecs[i].exp_first);
      chk({nm, " gap sclk"}, int'(sclk_h[vecs[i].exp_done - 4]), 0);
      chk({nm, " gap sdout"}, int'(sdout_h[vecs[i].exp_done - 4]), 0);
      chk({nm, " done pulses"}, done_cyc.size(), 1);
      if (done_cyc.size() > 0) chk({nm, " done cycle"}, done_cyc[0], vecs[i].exp_done);
      chk({nm, " cfg_ready at done"}, int'(rdy_h[vecs[i].exp_done]), 1);
      chk({nm, " busy at done"}, int'(busy_h[vecs[i].exp_done]), 0);
      chk({nm, " timeout pulses"}, tmo_cyc.size(), 0);
    end

    // Backend never ready
    start(5'b10110);
    run_cycles(70, 1000, 0, -1);
    chk("tmo pulses", tmo_cyc.size(), 1);
    if (tmo_cyc.size() > 0) chk("tmo cycle", tmo_cyc[0], 64);
    chk("tmo sclk rises", rise_cyc.size(), 0);
    chk("tmo done pulses", done_cyc.size(), 0);
    chk("tmo busy before", int'(busy_h[63]), 1);
    chk("tmo cfg_ready before", int'(rdy_h[63]), 0);
    chk("tmo cfg_ready after", int'(rdy_h[65]), 1);

    // Valid held with another word during a frame; only taken after done
    start(5'b00101);
    cfg_word = 5'b11111;
    run_cycles(60, 0, 26, -1);
    chk("busyrej rise count", rise_cyc.size(), 10);
    check_frame("busyrej f1", 0, 5'b00101, 3);
    check_frame("busyrej f2", 5, 5'b11111, 29);
    chk("busyrej done pulses", done_cyc.size(), 2);
    if (done_cyc.size() > 1) begin
      chk("busyrej done1 cycle", done_cyc[0], 25);
      chk("busyrej done2 cycle", done_cyc[1], 51);
    end

    // Reset after the second sclk rise
    start(5'b11111);
    run_cycles(30, 0, 0, 7);
    chk("midrst rises", rise_cyc.size(), 2);
    chk("midrst sclk", int'(sclk_h[8]), 0);
    chk("midrst sdout", int'(sdout_h[8]), 0);
    chk("midrst busy", int'(busy_h[8]), 0);
    chk("midrst cfg_ready", int'(rdy_h[8]), 1);
    chk("midrst done pulses", done_cyc.size(), 0);
    chk("midrst timeout pulses", tmo_cyc.size(), 0);

    start(cfg_pack(2'b01, 3'b101));
    run_cycles(29, 0, 0, -1);
    check_frame("postrst", 0, 5'b01101, 3);
    chk("postrst done pulses", done_cyc.size(), 1);
    if (done_cyc.size() > 0) chk("postrst done cycle", done_cyc[0], 25);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
